// File: rtl/sram_port_arbiter_if.sv
// Request/ack bundle for both requester ports plus the SRAM macro pins.
// slave: the arbiter's view; master: the requesters' and SRAM's view.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] sram_addr;
  logic              sram_addr_ready;
  logic              sram_read_pulse;
  logic              sram_write_pulse;
  logic [DATA_W-1:0] sram_datain;
  logic [DATA_W-1:0] sram_dataout;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_rdata,
    output sram_addr, sram_addr_ready, sram_read_pulse, sram_write_pulse, sram_datain,
    input  sram_dataout
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_rdata,
    input  sram_addr, sram_addr_ready, sram_read_pulse, sram_write_pulse, sram_datain,
    output sram_dataout
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port (fetch p0 / data p1) arbiter sequencing the SRAM addr/pulse phases.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed p1 priority.
module sram_port_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int PULSE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_port_arbiter_if.slave  bus,
  output logic                busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] PULSE   = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

  logic [2:0]        state;
  logic [3:0]        pulse_cnt;
  logic              we_q;
  logic              port_q;
  logic              any_req;
  logic              pick_p1;
  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_grant <= pick_p1;
    end
  end
`endif

  always_comb begin
    any_req = bus.p0_req | bus.p1_req;
`ifdef SRAM_ARB_RR_EN
    // Contested cycle goes to whichever port did not win last time.
    if (bus.p0_req && bus.p1_req) begin
      pick_p1 = ~last_grant;
    end else begin
      pick_p1 = bus.p1_req;
    end
`else
    pick_p1 = bus.p1_req;
`endif
    we_sel    = pick_p1 ? bus.p1_we    : bus.p0_we;
    addr_sel  = pick_p1 ? bus.p1_addr  : bus.p0_addr;
    wdata_sel = pick_p1 ? bus.p1_wdata : bus.p0_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      pulse_cnt            <= '0;
      we_q                 <= 1'b0;
      port_q               <= 1'b0;
      bus.sram_addr        <= '0;
      bus.sram_datain      <= '0;
      bus.sram_addr_ready  <= 1'b0;
      bus.sram_read_pulse  <= 1'b0;
      bus.sram_write_pulse <= 1'b0;
      bus.p0_ack           <= 1'b0;
      bus.p1_ack           <= 1'b0;
      bus.p0_rdata         <= '0;
      bus.p1_rdata         <= '0;
    end else begin
      bus.p0_ack <= 1'b0;
      bus.p1_ack <= 1'b0;
      case (state)
        IDLE: begin
          // Grant loads the SRAM address/data registers directly; they are
          // left untouched afterwards so they hold their last values.
          if (any_req) begin
            port_q              <= pick_p1;
            we_q                <= we_sel;
            bus.sram_addr       <= addr_sel;
            bus.sram_datain     <= wdata_sel;
            bus.sram_addr_ready <= 1'b1;
            state               <= SETUP;
          end
        end
        SETUP: begin
          pulse_cnt            <= '0;
          bus.sram_write_pulse <= we_q;
          bus.sram_read_pulse  <= ~we_q;
          state                <= PULSE;
        end
        PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            pulse_cnt            <= '0;
            bus.sram_write_pulse <= 1'b0;
            bus.sram_read_pulse  <= 1'b0;
            state                <= HOLD;
          end else begin
            pulse_cnt <= pulse_cnt + 4'd1;
          end
        end
        HOLD: begin
          if (!we_q) begin
            if (port_q) bus.p1_rdata <= bus.sram_dataout;
            else        bus.p0_rdata <= bus.sram_dataout;
          end
          if (port_q) bus.p1_ack <= 1'b1;
          else        bus.p0_ack <= 1'b1;
          bus.sram_addr_ready <= 1'b0;
          state               <= RELEASE;
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench: directed table, reset abort, contention, back-to-back
// and randomized traffic against a transaction-level memory/arbitration model.
module tb_sram_port_arbiter;

  localparam int PC0 = 1;
  localparam int PC3 = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b1;
  logic        sel = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [6:0]  p0_addr = '0, p1_addr = '0;
  logic [31:0] p0_wdata = '0, p1_wdata = '0;
  logic        busy0, busy3;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(7), .DATA_W(32)) b  ();
  sram_port_arbiter_if #(.ADDR_W(7), .DATA_W(32)) b3 ();

  sram_port_arbiter #(.ADDR_W(7), .DATA_W(32), .PULSE_CYCLES(PC0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b), .busy(busy0));
  sram_port_arbiter #(.ADDR_W(7), .DATA_W(32), .PULSE_CYCLES(PC3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .busy(busy3));

  assign b.p0_req   = p0_req & ~sel;
  assign b.p0_we    = p0_we;
  assign b.p0_addr  = p0_addr;
  assign b.p0_wdata = p0_wdata;
  assign b.p1_req   = p1_req & ~sel;
  assign b.p1_we    = p1_we;
  assign b.p1_addr  = p1_addr;
  assign b.p1_wdata = p1_wdata;
  assign b3.p0_req   = p0_req & sel;
  assign b3.p0_we    = p0_we;
  assign b3.p0_addr  = p0_addr;
  assign b3.p0_wdata = p0_wdata;
  assign b3.p1_req   = p1_req & sel;
  assign b3.p1_we    = p1_we;
  assign b3.p1_addr  = p1_addr;
  assign b3.p1_wdata = p1_wdata;

  // Behavioural SRAM macros: write on write_pulse, dataout loaded on read_pulse.
  logic [31:0] mem0 [128];
  logic [31:0] mem3 [128];
  logic [31:0] dout0, dout3;
  assign b.sram_dataout  = dout0;
  assign b3.sram_dataout = dout3;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 128; i++) begin
        mem0[i] <= '0;
        mem3[i] <= '0;
      end
      dout0 <= '0;
      dout3 <= '0;
    end else begin
      if (b.sram_write_pulse)  mem0[b.sram_addr]  <= b.sram_datain;
      if (b.sram_read_pulse)   dout0 <= mem0[b.sram_addr];
      if (b3.sram_write_pulse) mem3[b3.sram_addr] <= b3.sram_datain;
      if (b3.sram_read_pulse)  dout3 <= mem3[b3.sram_addr];
    end
  end

  logic        a0, a1, ws, rs, ar, bsy;
  logic [31:0] rdat0, rdat1;
  assign a0    = sel ? b3.p0_ack : b.p0_ack;
  assign a1    = sel ? b3.p1_ack : b.p1_ack;
  assign ws    = sel ? b3.sram_write_pulse : b.sram_write_pulse;
  assign rs    = sel ? b3.sram_read_pulse  : b.sram_read_pulse;
  assign ar    = sel ? b3.sram_addr_ready  : b.sram_addr_ready;
  assign bsy   = sel ? busy3 : busy0;
  assign rdat0 = sel ? b3.p0_rdata : b.p0_rdata;
  assign rdat1 = sel ? b3.p1_rdata : b.p1_rdata;

  int viol = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if ((b.sram_write_pulse && b.sram_read_pulse) ||
          ((b.sram_write_pulse || b.sram_read_pulse) && !b.sram_addr_ready)) viol++;
      if ((b3.sram_write_pulse && b3.sram_read_pulse) ||
          ((b3.sram_write_pulse || b3.sram_read_pulse) && !b3.sram_addr_ready)) viol++;
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference model for the PULSE_CYCLES=1 instance: word memory, last read per port,
  // and the last granted port.
  logic [31:0] mdl_mem [128];
  logic [31:0] mdl_last [2];
  bit          mdl_lg;

  function automatic void model_reset();
    mdl_last[0] = '0;
    mdl_last[1] = '0;
    mdl_lg = 1'b1;
  endfunction

  function automatic void model_op(input bit port, input bit we, input logic [6:0] a,
                                   input logic [31:0] d);
    if (we) mdl_mem[a] = d;
    else    mdl_last[port] = mdl_mem[a];
    mdl_lg = port;
  endfunction

  function automatic bit model_winner(input bit r0, input bit r1);
    if (!r1) return 1'b0;
    if (!r0) return 1'b1;
`ifdef SRAM_ARB_RR_EN
    return ~mdl_lg;
`else
    return 1'b1;
`endif
  endfunction

  task automatic do_round(
    input bit r0, input bit w0, input logic [6:0] ad0, input logic [31:0] d0,
    input bit r1, input bit w1, input logic [6:0] ad1, input logic [31:0] d1,
    output int c0, output int c1, output logic [31:0] rd0, output logic [31:0] rd1,
    output int extra, output logic [31:0] wm, output logic [31:0] rm, output logic [31:0] am);
    bit pend0, pend1;
    c0 = -1; c1 = -1; rd0 = '0; rd1 = '0; extra = 0; wm = '0; rm = '0; am = '0;
    @(posedge clk); #1;
    p0_req = r0; p0_we = w0; p0_addr = ad0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = ad1; p1_wdata = d1;
    pend0 = r0; pend1 = r1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      wm[c] = ws;
      rm[c] = rs;
      am[c] = ar;
      if (a0) begin
        if (pend0) begin c0 = c; rd0 = rdat0; pend0 = 1'b0; end
        else extra++;
      end
      if (a1) begin
        if (pend1) begin c1 = c; rd1 = rdat1; pend1 = 1'b0; end
        else extra++;
      end
      @(posedge clk); #1;
      if (!pend0) p0_req = 1'b0;
      if (!pend1) p1_req = 1'b0;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  task automatic run_and_check(input string tag,
    input bit r0, input bit w0, input logic [6:0] ad0, input logic [31:0] d0,
    input bit r1, input bit w1, input logic [6:0] ad1, input logic [31:0] d1);
    int c0, c1, ex, e0, e1;
    logic [31:0] rd0, rd1, wm, rm, am;
    bit w;
    w = model_winner(r0, r1);
    e0 = -1; e1 = -1;
    // First grant completes at PC+3; the loser follows one access period later.
    if (w == 1'b0) begin
      e0 = PC0 + 3; model_op(1'b0, w0, ad0, d0);
      if (r1) begin e1 = 2 * PC0 + 7; model_op(1'b1, w1, ad1, d1); end
    end else begin
      e1 = PC0 + 3; model_op(1'b1, w1, ad1, d1);
      if (r0) begin e0 = 2 * PC0 + 7; model_op(1'b0, w0, ad0, d0); end
    end
    do_round(r0, w0, ad0, d0, r1, w1, ad1, d1, c0, c1, rd0, rd1, ex, wm, rm, am);
    chk({tag, "_p0_ack_cycle"}, c0, e0);
    chk({tag, "_p1_ack_cycle"}, c1, e1);
    if (r0) chk({tag, "_p0_rdata"}, rd0, mdl_last[0]);
    if (r1) chk({tag, "_p1_rdata"}, rd1, mdl_last[1]);
    chk({tag, "_extra_acks"}, ex, 0);
  endtask

  typedef struct {
    bit          sel;
    bit          port;
    bit          we;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [10];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int          c0, c1, ex, pc, k, m;
    logic [31:0] rd0, rd1, wm, rm, am, rd_got;
    bit          found, got, acks;

    vt[0] = '{1'b0, 1'b0, 1'b1, 7'h05, 32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 7'h05, 32'h0,        32'hDEADBEEF};
    vt[2] = '{1'b0, 1'b1, 1'b1, 7'h7F, 32'hFFFFFFFF, 32'h0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 7'h00, 32'h00000001, 32'h0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 7'h7F, 32'h0,        32'hFFFFFFFF};
    vt[5] = '{1'b0, 1'b1, 1'b0, 7'h00, 32'h0,        32'h00000001};
    vt[6] = '{1'b0, 1'b0, 1'b1, 7'h10, 32'hCAFEF00D, 32'hFFFFFFFF};
    vt[7] = '{1'b1, 1'b0, 1'b1, 7'h33, 32'hA5A55A5A, 32'h0};
    vt[8] = '{1'b1, 1'b0, 1'b0, 7'h33, 32'h0,        32'hA5A55A5A};
    vt[9] = '{1'b1, 1'b1, 1'b0, 7'h33, 32'h0,        32'hA5A55A5A};

    for (int i = 0; i < 128; i++) mdl_mem[i] = '0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_addr_ready", b.sram_addr_ready, 1'b0);
    chk("reset_pulses", {b.sram_write_pulse, b.sram_read_pulse}, 2'b00);
    chk("reset_addr_datain", {b.sram_addr, b.sram_datain}, '0);
    chk("reset_acks", {b.p0_ack, b.p1_ack}, 2'b00);
    chk("reset_rdata", {b.p0_rdata, b.p1_rdata}, '0);
    chk("reset_busy", {busy0, busy3}, 2'b00);
    rst_n = 1'b1;
    clr   = 1'b0;

    for (int i = 0; i < 10; i++) begin
      sel = vt[i].sel;
      pc  = vt[i].sel ? PC3 : PC0;
      do_round(!vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata,
               vt[i].port,  vt[i].we, vt[i].addr, vt[i].wdata,
               c0, c1, rd0, rd1, ex, wm, rm, am);
      chk("vec_ack_cycle", vt[i].port ? c1 : c0, pc + 3);
      chk("vec_idle_port_no_ack", vt[i].port ? c0 : c1, -1);
      chk("vec_rdata", vt[i].port ? rd1 : rd0, vt[i].exp_rd);
      chk("vec_pulse_window", vt[i].we ? wm : rm, ((32'd1 << pc) - 32'd1) << 2);
      chk("vec_wrong_pulse", vt[i].we ? rm : wm, 32'h0);
      chk("vec_addr_ready_window", am, ((32'd1 << (pc + 2)) - 32'd1) << 1);
      chk("vec_extra_acks", ex, 0);
      if (!vt[i].sel) model_op(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata);
    end
    sel = 1'b0;

    // Abort a write in its PULSE phase.
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 7'h30; p0_wdata = 32'hBADC0DE1;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b.sram_write_pulse) begin found = 1'b1; break; end
    end
    chk("rst_mid_found_pulse", found, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pulses", {b.sram_write_pulse, b.sram_read_pulse}, 2'b00);
    chk("rst_mid_addr_ready", b.sram_addr_ready, 1'b0);
    chk("rst_mid_busy", busy0, 1'b0);
    chk("rst_mid_rdata", b.p0_rdata, 32'h0);
    p0_req = 1'b0;
    acks = 1'b0;
    repeat (3) begin
      @(negedge clk);
      acks = acks | b.p0_ack | b.p1_ack;
    end
    chk("rst_mid_no_ack", acks, 1'b0);
    rst_n = 1'b1;
    model_reset();

    run_and_check("contend1", 1'b1, 1'b0, 7'h10, 32'h0, 1'b1, 1'b1, 7'h11, 32'h12345678);
    run_and_check("contend2", 1'b1, 1'b0, 7'h11, 32'h0, 1'b1, 1'b1, 7'h10, 32'h0BADF00D);
    run_and_check("post_rst_read", 1'b1, 1'b0, 7'h05, 32'h0, 1'b0, 1'b0, 7'h0, 32'h0);

    for (int i = 0; i < 4; i++)
      run_and_check("b2b_wr", 1'b0, 1'b0, 7'h0, 32'h0,
                    1'b1, 1'b1, 7'(32 + i), 32'h10000000 + 32'(i) * 32'h111);

    // p1 keeps req high across four reads, moving the address after each ack.
    k = 0;
    @(posedge clk); #1;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 7'h20;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      got = a1;
      rd_got = rdat1;
      if (got) begin
        if (k < 4) begin
          chk("b2b_ack_cycle", c, 4 + 5 * k);
          model_op(1'b1, 1'b0, 7'(32 + k), 32'h0);
          chk("b2b_rdata", rd_got, mdl_last[1]);
        end
        k++;
      end
      @(posedge clk); #1;
      if (got) begin
        if (k >= 4) p1_req = 1'b0;
        else p1_addr = 7'(32 + k);
      end
    end
    chk("b2b_ack_count", k, 4);
    chk("b2b_idle_after", busy0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      m = int'($urandom_range(0, 2));
      run_and_check("rand",
                    m != 1, 1'($urandom_range(0, 1)), 7'($urandom_range(64, 71)), 32'($urandom),
                    m != 0, 1'($urandom_range(0, 1)), 7'($urandom_range(64, 71)), 32'($urandom));
    end

    chk("pulse_protocol_violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
